// File: rtl/msp430_arb_pkg.sv
// -----------------------------------------------------------------------------
// msp430_arb_pkg
//   Shared types and helpers for the single-port RAM arbiter.
//   - arb_state_t : lock FSM state (RR = plain round-robin, LOCKED = owner held)
//   - rr_pick()   : round-robin one-hot picker, searching from a priority
//                   pointer and wrapping modulo the number of requesters
// -----------------------------------------------------------------------------
package msp430_arb_pkg;

    typedef enum logic {
        RR     = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Widest requester vector rr_pick() can handle; callers zero-extend.
    localparam int unsigned MAX_NODES = 32;
    localparam int unsigned MAX_IW    = $clog2(MAX_NODES);

    // Returns a one-hot vector selecting the first set bit of req at or after
    // index ptr, searching modulo nodes. Returns all-zero when req is empty.
    function automatic logic [MAX_NODES-1:0] rr_pick(
        input logic [MAX_NODES-1:0] req,
        input int unsigned          ptr,
        input int unsigned          nodes
    );
        logic [MAX_NODES-1:0] gnt;
        logic                 found;
        int unsigned          idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_NODES; i++) begin
            if (i < nodes) begin
                idx = ptr + i;
                if (idx >= nodes) begin
                    idx = idx - nodes;
                end
                if (!found && req[idx[MAX_IW-1:0]]) begin
                    gnt[idx[MAX_IW-1:0]] = 1'b1;
                    found                = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/msp430_rr_arbiter.sv
// -----------------------------------------------------------------------------
// msp430_rr_arbiter
//   Pure combinational round-robin picker. Requests with their mask bit set
//   are ignored; the winner is the first remaining request at or after ptr_i.
//
//   Ports
//     req_i  [NODES-1:0]  request vector
//     mask_i [NODES-1:0]  1 = exclude that requester from this search
//     ptr_i  [PW-1:0]     highest-priority index
//     gnt_o  [NODES-1:0]  one-hot winner, or zero if nothing eligible
// -----------------------------------------------------------------------------
module msp430_rr_arbiter
    import msp430_arb_pkg::*;
#(
    parameter int unsigned NODES = 4,
    parameter int unsigned PW    = $clog2(NODES)
) (
    input  logic [NODES-1:0] req_i,
    input  logic [NODES-1:0] mask_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [NODES-1:0] gnt_o
);

    logic [MAX_NODES-1:0] wide_req;
    logic [MAX_NODES-1:0] wide_gnt;

    always_comb begin
        wide_req             = '0;
        wide_req[NODES-1:0]  = req_i & ~mask_i;
        wide_gnt             = rr_pick(wide_req, 32'(ptr_i), NODES);
        gnt_o                = wide_gnt[NODES-1:0];
    end

endmodule

// File: rtl/msp430_spram_arbiter.sv
// -----------------------------------------------------------------------------
// msp430_spram_arbiter
//   Shares one single-port synchronous RAM between NODES requesters.
//   Zero-latency round-robin grant, one access per cycle, with a bounded lock
//   (up to MAX_LOCK consecutive grants) for read-modify-write style sequences.
//   Read data returns one cycle after the grant, tagged by rvalid_o.
//
//   Ports
//     clk, rst            clock; synchronous active-high reset
//     req_i   [NODES]     per-requester access request
//     we_i    [NODES]     1 = write, 0 = read
//     lock_i  [NODES]     keep the grant next cycle if still requesting
//     addr_i  [NODES][AW] request address
//     din_i   [NODES][DW] write data
//     gnt_o   [NODES]     one-hot grant, transfer happens this cycle
//     rvalid_o[NODES]     one-hot read-data-valid, one cycle after read grant
//     rdata_o [DW]        read data (RAM output passed through)
//     ram_addr_o/ram_din_o/ram_en_o/ram_we_o  RAM drive
//     ram_dout_i [DW]     RAM read data (1-cycle latency)
// -----------------------------------------------------------------------------
module msp430_spram_arbiter
    import msp430_arb_pkg::*;
#(
    parameter int unsigned NODES    = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NODES-1:0]          req_i,
    input  logic [NODES-1:0]          we_i,
    input  logic [NODES-1:0]          lock_i,
    input  logic [NODES-1:0][AW-1:0]  addr_i,
    input  logic [NODES-1:0][DW-1:0]  din_i,
    output logic [NODES-1:0]          gnt_o,
    output logic [NODES-1:0]          rvalid_o,
    output logic [DW-1:0]             rdata_o,
    output logic [AW-1:0]             ram_addr_o,
    output logic [DW-1:0]             ram_din_o,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    input  logic [DW-1:0]             ram_dout_i
);

    localparam int unsigned PW  = $clog2(NODES);
    localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NODES-1:0] rd_pend_q, rd_pend_d;

    logic [NODES-1:0] owner_oh;
    logic             lock_hold;
    logic             others_req;
    logic [NODES-1:0] rr_mask;
    logic [NODES-1:0] rr_gnt;
    logic [PW-1:0]    rr_idx;
    logic [NODES-1:0] gnt;
    logic [PW-1:0]    win_idx;

    // Lock bookkeeping -------------------------------------------------------
    always_comb begin
        owner_oh   = '0;
        owner_oh[owner_q] = 1'b1;
        // The owner keeps the grant while it still requests and has budget left.
        lock_hold  = (state_q == LOCKED) && req_i[owner_q] &&
                     (lock_cnt_q < LCW'(MAX_LOCK));
        others_req = |(req_i & ~owner_oh);
        // On release the previous owner steps aside, but only if someone else
        // is waiting; otherwise it may win again immediately.
        rr_mask    = ((state_q == LOCKED) && others_req) ? owner_oh : '0;
    end

    msp430_rr_arbiter #(
        .NODES (NODES),
        .PW    (PW)
    ) u_rr (
        .req_i  (req_i),
        .mask_i (rr_mask),
        .ptr_i  (ptr_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        rr_idx = '0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (rr_gnt[i]) begin
                rr_idx = PW'(i);
            end
        end
    end

    // Next-state / grant -----------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        ptr_d      = ptr_q;
        gnt        = '0;
        win_idx    = '0;

        if (lock_hold) begin
            gnt        = owner_oh;
            win_idx    = owner_q;
            lock_cnt_d = lock_cnt_q + LCW'(1);
            state_d    = lock_i[owner_q] ? LOCKED : RR;
        end else begin
            gnt        = rr_gnt;
            win_idx    = rr_idx;
            state_d    = RR;
            lock_cnt_d = '0;
            if ((|rr_gnt) && lock_i[rr_idx]) begin
                state_d    = LOCKED;
                owner_d    = rr_idx;
                lock_cnt_d = LCW'(1);
            end
        end

        if (|gnt) begin
            ptr_d = (win_idx == PW'(NODES - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    // Outputs: forced idle while reset is held, even before the first edge.
    always_comb begin
        gnt_o      = rst ? '0 : gnt;
        ram_en_o   = |gnt_o;
        ram_we_o   = ram_en_o & we_i[win_idx];
        ram_addr_o = ram_en_o ? addr_i[win_idx] : '0;
        ram_din_o  = ram_en_o ? din_i[win_idx]  : '0;
        rd_pend_d  = gnt_o & ~we_i;
        rvalid_o   = rst ? '0 : rd_pend_q;
        rdata_o    = rst ? '0 : ram_dout_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RR;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            ptr_q      <= '0;
            rd_pend_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            ptr_q      <= ptr_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

endmodule

// File: doc/msp430_spram_arbiter.md
# msp430_spram_arbiter

Round-robin arbiter that shares one single-port synchronous RAM (the `msp430_ram` macro used per node in the MPSoC wrappers) between `NODES` requesters. It sits between the external block-RAM ports of several tiles and a single RAM instance. It grants at most one access per cycle, drives the RAM address/data/enable/write strobes, and routes the one-cycle-late read data back to the winning requester. It supports a bounded lock so a requester can run back-to-back accesses, such as read-modify-write, without being interleaved.

## Interface
Parameters:
- `NODES`, 4, number of requesters (≥2)
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_LOCK`, 4, maximum consecutive grants to one locked requester before a forced release

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_i`  in  NODES  access request, per requester
- `we_i`  in  NODES  1 = write, 0 = read
- `lock_i`  in  NODES  keep the grant on the next cycle if still requesting
- `addr_i`  in  NODES×AW  request address
- `din_i`  in  NODES×DW  write data
- `gnt_o`  out  NODES  one-hot grant (combinational); access is performed this cycle
- `rvalid_o`  out  NODES  one-hot read-data-valid, one cycle after a read grant
- `rdata_o`  out  DW  read data, meaningful only while any `rvalid_o` bit is high
- `ram_addr_o`  out  AW  to RAM address
- `ram_din_o`  out  DW  to RAM write data
- `ram_en_o`  out  1  RAM enable, active-high
- `ram_we_o`  out  1  RAM write enable
- `ram_dout_i`  in  DW  RAM read data (registered inside the RAM, 1-cycle latency)

## Operation
- Requester protocol:
  - Raise `req_i[k]` with `we_i`, `addr_i` and `din_i` stable.
  - Hold all of them unchanged until the cycle where `gnt_o[k]`=1. That cycle is the transfer.
  - Drop `req_i[k]` or present the next request in the following cycle.
- Arbitration:
  - State is `ptr` (the index with highest priority) plus lock state.
  - In IDLE/RR, the grant goes to the first requesting index at or after `ptr`, searching modulo `NODES`.
  - After a grant to index g, `ptr` ← (g+1) mod `NODES`.
- Lock FSM:
  - States are RR and LOCKED, with `owner` and `lock_cnt` (width clog2(`MAX_LOCK`+1)).
  - RR→LOCKED when the granted requester g has `lock_i[g]`=1. Then `owner`←g and `lock_cnt`←1.
  - In LOCKED with `req_i[owner]`=1 and `lock_cnt`<`MAX_LOCK`:
    - The grant goes to `owner` regardless of `ptr`.
    - `lock_cnt` increments.
    - The state stays LOCKED only while `lock_i[owner]`=1; otherwise it returns to RR.
  - In LOCKED with `req_i[owner]`=0, or with `lock_cnt`=`MAX_LOCK`:
    - Normal RR arbitration applies this cycle.
    - `owner` is excluded from the search if other requests exist.
    - The state returns to RR.
  - `ptr` always advances past the last granted index.
- RAM drive:
  - `ram_en_o` = |`gnt_o`.
  - `ram_we_o` = `we_i` of the winner.
  - `ram_addr_o` / `ram_din_o` are muxed from the winner.
  - With no grant, addr/din are 0 and `ram_we_o`=0.
- Read return:
  - A registered one-hot `rd_pend` ← `gnt_o & ~we_i` each cycle.
  - `rvalid_o` = `rd_pend`.
  - `rdata_o` = `ram_dout_i` passed through combinationally.
- Writes produce no response; a granted write is complete.
- Fairness: a continuously requesting unlocked requester is granted within (`NODES`−1)×`MAX_LOCK`+1 cycles.

## Timing
- Grant latency: 0 cycles. `gnt_o` is asserted in the same cycle as `req_i` if the requester wins.
- Throughput: one access per cycle. Back-to-back grants to different requesters are allowed.
- Read data: on `rdata_o` with `rvalid_o[k]`=1 exactly one cycle after the grant cycle.
- Reset, while `rst`=1:
  - `gnt_o`=0, `ram_en_o`=0, `ram_we_o`=0, `ram_addr_o`=0, `ram_din_o`=0.
  - `rvalid_o`=0 and `rdata_o`=0, with `rd_pend` cleared.
  - `ptr`=0, state RR, `lock_cnt`=0.
- Reset asserted the cycle after a read grant: the pending `rvalid_o` is suppressed.
- Simultaneous requests from all indices: exactly one `gnt_o` bit is set, never more.
- `ptr` wraps from `NODES`−1 to 0.
- `lock_i` asserted without a grant has no effect.

## Structure
- Shared package `msp430_arb_pkg` holds:
  - the FSM state enum `arb_state_t` {RR, LOCKED};
  - the function `rr_pick(req, ptr)`, which returns a one-hot vector.
- Natural sub-module: `msp430_rr_arbiter`, a pure round-robin one-hot picker with mask input.
- The parent holds the lock FSM, the RAM mux and the read-return register.

## Test plan
- Single read (`NODES`=4): req[2] read at addr 0x10, which was preloaded with 0xDEADBEEF.
  - Required: `gnt_o`=0100 in the same cycle, `ram_en_o`=1, `ram_we_o`=0.
  - Next cycle: `rvalid_o`=0100, `rdata_o`=0xDEADBEEF.
- All four requesting continuously, no lock, from reset:
  - Grant sequence 0,1,2,3,0,1… with no idle cycles.
  - `ram_en_o` high every cycle.
- Lock with `MAX_LOCK`=4: req[1] and req[3] both high, `lock_i[1]`=1 throughout.
  - Required: grants 1,1,1,1, then 3, then 1 resumes.
- Write then read: req[0] write 0xA5A5A5A5 to addr 0x20, then a read of 0x20.
  - Required: no `rvalid_o` after the write.
  - Read returns 0xA5A5A5A5 with `rvalid_o`=0001.
- Reset mid-read: read granted to req[3], `rst`=1 on the next cycle.
  - Required: `rvalid_o`=0, all RAM outputs 0.
  - After release, `ptr`=0, so a simultaneous req[0] and req[3] grants 0 first.
- Lock drop: `lock_i[2]` deasserts on the 2nd of 3 consecutive grants while req[0] is pending.
  - Required: the third grant goes to 0, not 2.
